// File: rtl/csi_rx_stream_ctrl_if.sv
// Signal bundle between the CSI receive supervision controller and its environment.
// The master side drives run/lock and depacketizer strobes; the slave side is the controller.
interface csi_rx_stream_ctrl_if;
  logic        start;
  logic        clk_locked;
  logic        in_frame;
  logic        in_line;
  logic        pix_vld;
  logic        cam_en;
  logic [2:0]  state;
  logic [11:0] line_cnt;
  logic        frame_ok;
  logic        geom_err;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  modport master (
    output start, clk_locked, in_frame, in_line, pix_vld,
    input  cam_en, state, line_cnt, frame_ok, geom_err, frame_cnt, err_cnt
  );

  modport slave (
    input  start, clk_locked, in_frame, in_line, pix_vld,
    output cam_en, state, line_cnt, frame_ok, geom_err, frame_cnt, err_cnt
  );
endinterface

// File: rtl/csi_rx_stream_ctrl.sv
// CSI receive bring-up/supervision FSM: arms the datapath, checks frame geometry, recovers stalls.
// Optional statistics counters are built only when CSI_RX_STREAM_STATS_EN is defined.
module csi_rx_stream_ctrl #(
  parameter int H_BEATS     = 960,
  parameter int V_LINES     = 1080,
  parameter int ARM_CYC     = 16,
  parameter int SOF_TIMEOUT = 1_000_000,
  parameter int HOLD_CYC    = 64,
  parameter int MAX_RETRY   = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  csi_rx_stream_ctrl_if.slave bus
);

  localparam int TMAX_AS = (ARM_CYC > SOF_TIMEOUT) ? ARM_CYC : SOF_TIMEOUT;
  localparam int TMAX    = (TMAX_AS > HOLD_CYC) ? TMAX_AS : HOLD_CYC;
  localparam int TW      = $clog2(TMAX + 1);
  localparam int RW      = $clog2(MAX_RETRY + 2);

  localparam logic [TW-1:0] ARM_LAST  = TW'(ARM_CYC - 1);
  localparam logic [TW-1:0] SOF_LAST  = TW'(SOF_TIMEOUT - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYC - 1);
  localparam logic [RW-1:0] RET_MAX   = RW'(MAX_RETRY);
  localparam logic [15:0]   H_EXP     = 16'(H_BEATS);
  localparam logic [11:0]   V_EXP     = 12'(V_LINES);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_WAIT_SOF = 3'd2,
    ST_STREAM   = 3'd3,
    ST_RECOVER  = 3'd4,
    ST_FAIL     = 3'd5
  } state_e;

  state_e          state_q, state_d, nxt_state;
  logic [TW-1:0]   timer_q, timer_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [15:0]     beat_q, beat_d;
  logic [11:0]     line_q, line_d;
  logic            ferr_q, ferr_d;
  logic            cam_en_q, cam_en_d;
  logic            frame_ok_q, frame_ok_d;
  logic            geom_err_q, geom_err_d;
  logic            frm_q, frm_p_q, lin_q, lin_p_q, pix_q;
  logic            eof_ok, eof_bad, force_idle;

  // Edges are taken on the registered strobes so every decision is fully registered.
  wire frm_rise = frm_q & ~frm_p_q;
  wire frm_fall = ~frm_q & frm_p_q;
  wire lin_rise = lin_q & ~lin_p_q;
  wire lin_fall = ~lin_q & lin_p_q;
  wire lin_edge = lin_rise | lin_fall;

  assign force_idle = !bus.start ||
                      (!bus.clk_locked && (state_q inside {ST_ARM, ST_WAIT_SOF, ST_STREAM, ST_RECOVER}));
  assign state_d    = force_idle ? ST_IDLE : nxt_state;
  assign frame_ok_d = eof_ok & ~force_idle;
  assign geom_err_d = eof_bad & ~force_idle;
  assign cam_en_d   = (state_d == ST_ARM) || (state_d == ST_WAIT_SOF) || (state_d == ST_STREAM);

  // Next-state and datapath update; the frame check uses the line count including a line closing now.
  always_comb begin
    nxt_state = state_q;
    timer_d   = timer_q;
    retry_d   = retry_q;
    beat_d    = beat_q;
    line_d    = line_q;
    ferr_d    = ferr_q;
    eof_ok    = 1'b0;
    eof_bad   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        retry_d = '0;
        beat_d  = 16'd0;
        line_d  = 12'd0;
        ferr_d  = 1'b0;
        if (bus.start && bus.clk_locked) nxt_state = ST_ARM;
        else                             nxt_state = ST_IDLE;
      end
      ST_ARM: begin
        if (timer_q == ARM_LAST) begin
          nxt_state = ST_WAIT_SOF;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_WAIT_SOF: begin
        if (frm_rise) begin
          nxt_state = ST_STREAM;
          retry_d   = '0;
          line_d    = 12'd0;
          beat_d    = 16'd0;
          ferr_d    = 1'b0;
          timer_d   = '0;
        end else if (timer_q == SOF_LAST) begin
          nxt_state = ST_RECOVER;
          retry_d   = retry_q + RW'(1);
          timer_d   = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_STREAM: begin
        if (pix_q && lin_q && (beat_q != 16'hFFFF)) beat_d = beat_q + 16'd1;
        else                                        beat_d = beat_q;
        if (lin_fall) begin
          if (beat_q != H_EXP) ferr_d = 1'b1;
          else                 ferr_d = ferr_q;
          if (line_q != 12'hFFF) line_d = line_q + 12'd1;
          else                   line_d = line_q;
          beat_d = 16'd0;
        end else begin
          line_d = line_q;
        end
        if (lin_edge) timer_d = '0;
        else          timer_d = timer_q + TW'(1);
        // A rise without a seen fall closes the old frame as bad and opens a new one in place.
        if (frm_fall || frm_rise) begin
          if (!frm_rise && (line_d == V_EXP) && !ferr_d) eof_ok = 1'b1;
          else                                           eof_bad = 1'b1;
          timer_d = '0;
          if (frm_rise) begin
            line_d = 12'd0;
            beat_d = 16'd0;
            ferr_d = 1'b0;
          end else begin
            nxt_state = ST_WAIT_SOF;
          end
        end else if ((timer_q == SOF_LAST) && !lin_edge) begin
          nxt_state = ST_RECOVER;
          retry_d   = retry_q + RW'(1);
          timer_d   = '0;
        end else begin
          nxt_state = ST_STREAM;
        end
      end
      ST_RECOVER: begin
        if (timer_q == HOLD_LAST) begin
          timer_d = '0;
          if (retry_q == RET_MAX) nxt_state = ST_FAIL;
          else                    nxt_state = ST_ARM;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_FAIL: nxt_state = ST_FAIL;
      default: nxt_state = ST_IDLE;
    endcase
  end

  // State, datapath and registered-output flops plus the input sampling stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      retry_q    <= '0;
      beat_q     <= 16'd0;
      line_q     <= 12'd0;
      ferr_q     <= 1'b0;
      cam_en_q   <= 1'b0;
      frame_ok_q <= 1'b0;
      geom_err_q <= 1'b0;
      frm_q      <= 1'b0;
      frm_p_q    <= 1'b0;
      lin_q      <= 1'b0;
      lin_p_q    <= 1'b0;
      pix_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      beat_q     <= beat_d;
      line_q     <= line_d;
      ferr_q     <= ferr_d;
      cam_en_q   <= cam_en_d;
      frame_ok_q <= frame_ok_d;
      geom_err_q <= geom_err_d;
      frm_q      <= bus.in_frame;
      frm_p_q    <= frm_q;
      lin_q      <= bus.in_line;
      lin_p_q    <= lin_q;
      pix_q      <= bus.pix_vld;
    end
  end

  assign bus.cam_en   = cam_en_q;
  assign bus.state    = state_q;
  assign bus.line_cnt = line_q;
  assign bus.frame_ok = frame_ok_q;
  assign bus.geom_err = geom_err_q;

`ifdef CSI_RX_STREAM_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;
  wire rec_entry = (state_d == ST_RECOVER) && (state_q != ST_RECOVER);

  // Good-frame counter wraps; error counter saturates so a flood of faults stays visible.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= 16'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      if (frame_ok_d) frame_cnt_q <= frame_cnt_q + 16'd1;
      else            frame_cnt_q <= frame_cnt_q;
      if ((geom_err_d || rec_entry) && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
      else                                                   err_cnt_q <= err_cnt_q;
    end
  end

  assign bus.frame_cnt = frame_cnt_q;
  assign bus.err_cnt   = err_cnt_q;
`else
  assign bus.frame_cnt = 16'd0;
  assign bus.err_cnt   = 8'd0;
`endif

endmodule

// File: tb/tb_csi_rx_stream_ctrl.sv
// Randomized scoreboard bench for csi_rx_stream_ctrl: frames are modelled as lists of beat counts,
// expected end-of-frame pulses are queued at stimulus time and matched by an independent monitor.
module tb_csi_rx_stream_ctrl;
  localparam int HB   = 8;
  localparam int VL   = 4;
  localparam int ARM  = 16;
  localparam int SOFT = 100;
  localparam int HOLD = 64;
  localparam int MR   = 3;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  csi_rx_stream_ctrl_if bus();

  csi_rx_stream_ctrl #(
    .H_BEATS(HB), .V_LINES(VL), .ARM_CYC(ARM),
    .SOF_TIMEOUT(SOFT), .HOLD_CYC(HOLD), .MAX_RETRY(MR)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    bit ok;
    int due;
    int lines;
    int fcnt;
    int ecnt;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   m_fcnt = 0;
  int   m_ecnt = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int stat(input int v);
`ifdef CSI_RX_STREAM_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // Monitor: every end-of-frame pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (reset_n && (bus.frame_ok || bus.geom_err)) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_pulse: frame_ok=%0b geom_err=%0b, none expected (cycle %0d)",
                 bus.frame_ok, bus.geom_err, cyc);
      end else begin
        mon_e = sbq.pop_front();
        check("eof_frame_ok", bus.frame_ok, mon_e.ok);
        check("eof_geom_err", bus.geom_err, !mon_e.ok);
        check("eof_cycle", cyc, mon_e.due);
        check("eof_line_cnt", bus.line_cnt, mon_e.lines);
        check("eof_frame_cnt", bus.frame_cnt, stat(mon_e.fcnt));
        check("eof_err_cnt", bus.err_cnt, stat(mon_e.ecnt));
      end
    end
  end

  task automatic wait_state(input int st, input int budget, input string nm);
    int n = 0;
    while (bus.state != st && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(nm, bus.state, st);
  endtask

  // Drives one line of nb valid beats; optionally ends the frame together with the line.
  task automatic send_line(input int nb, input bit close_frame, output int t_close);
    int sent = 0;
    t_close = -1;
    @(negedge clock);
    bus.in_line = 1'b1;
    bus.pix_vld = 1'b0;
    while (sent < nb) begin
      @(negedge clock);
      bus.pix_vld = ($urandom_range(0, 3) != 0);
      if (bus.pix_vld) sent++;
    end
    @(negedge clock);
    bus.pix_vld = 1'b0;
    bus.in_line = 1'b0;
    if (close_frame) begin
      bus.in_frame = 1'b0;
      t_close = cyc;
    end
  endtask

  task automatic send_frame(input int nlines, input int bad_line, input int bad_beats, input bit sim_end);
    bit ok;
    int t_end;
    int nb;
    bit last;
    ok = (nlines == VL);
    t_end = -1;
    @(negedge clock);
    bus.in_frame = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clock);
    for (int l = 0; l < nlines; l++) begin
      nb   = (l == bad_line) ? bad_beats : HB;
      last = sim_end && (l == nlines - 1);
      if (nb != HB) ok = 1'b0;
      send_line(nb, last, t_end);
      if (!last) begin
        @(negedge clock);
        bus.pix_vld = ($urandom_range(0, 1) != 0);
        @(negedge clock);
        bus.pix_vld = 1'b0;
      end
    end
    if (!sim_end) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      @(negedge clock);
      bus.in_frame = 1'b0;
      t_end = cyc;
    end
    if (ok) m_fcnt = (m_fcnt + 1) % 65536;
    else    m_ecnt = (m_ecnt < 255) ? m_ecnt + 1 : 255;
    sbq.push_back('{ok, t_end + 2, (nlines > 4095) ? 4095 : nlines, m_fcnt, m_ecnt});
    repeat ($urandom_range(3, 6)) @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int kind, nl, bl, bb, c;
    int hi, lo, falls, n;

    bus.start = 1'b0; bus.clk_locked = 1'b0;
    bus.in_frame = 1'b0; bus.in_line = 1'b0; bus.pix_vld = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_state", bus.state, 0);
    check("rst_cam_en", bus.cam_en, 0);
    check("rst_line_cnt", bus.line_cnt, 0);
    check("rst_frame_ok", bus.frame_ok, 0);
    check("rst_geom_err", bus.geom_err, 0);
    check("rst_frame_cnt", bus.frame_cnt, 0);
    check("rst_err_cnt", bus.err_cnt, 0);

    // Nominal bring-up and three good frames.
    bus.start = 1'b1; bus.clk_locked = 1'b1; reset_n = 1'b1;
    @(negedge clock);
    check("cam_en_after_start", bus.cam_en, 1);
    check("state_arm", bus.state, 1);
    wait_state(2, 40, "arm_to_wait_sof");
    repeat (3) send_frame(VL, -1, 0, 1'b0);
    check("line_cnt_hold", bus.line_cnt, VL);
    check("frame_cnt_after_3", bus.frame_cnt, stat(3));

    // Short line, then recovery with a good frame, then randomized frames.
    send_frame(VL, 2, HB - 1, 1'b0);
    send_frame(VL, -1, 0, 1'b0);
    for (int f = 0; f < 10; f++) begin
      kind = $urandom_range(0, 3);
      nl = VL; bl = -1; bb = HB;
      if (kind == 2) begin
        bl = $urandom_range(0, VL - 1);
        bb = ($urandom_range(0, 1) != 0) ? HB + $urandom_range(1, 2) : HB - $urandom_range(1, 2);
      end else if (kind == 3) begin
        nl = ($urandom_range(0, 1) != 0) ? VL + 1 : VL - 1;
      end
      send_frame(nl, bl, bb, $urandom_range(0, 3) == 0);
    end

    // Line and frame closing in the same cycle on the last line.
    send_frame(VL, -1, 0, 1'b1);
    check("sim_end_line_cnt", bus.line_cnt, VL);

    // Lock loss in the middle of a frame.
    @(negedge clock);
    bus.in_frame = 1'b1;
    repeat (3) @(negedge clock);
    bus.in_line = 1'b1; bus.pix_vld = 1'b1;
    repeat (3) @(negedge clock);
    check("lock_pre_stream", bus.state, 3);
    bus.clk_locked = 1'b0;
    @(negedge clock);
    check("lock_loss_state", bus.state, 0);
    check("lock_loss_cam_en", bus.cam_en, 0);
    bus.in_line = 1'b0; bus.pix_vld = 1'b0; bus.in_frame = 1'b0;
    repeat (5) @(negedge clock);
    check("lock_low_idle", bus.state, 0);
    bus.clk_locked = 1'b1;
    @(negedge clock);
    check("relock_arm", bus.state, 1);
    check("relock_cam_en", bus.cam_en, 1);
    repeat (ARM - 1) @(negedge clock);
    check("relock_arm_last", bus.state, 1);
    @(negedge clock);
    check("relock_wait_sof", bus.state, 2);

    // Watchdog: three recoveries without traffic, then FAIL.
    bus.start = 1'b0;
    @(negedge clock);
    check("stop_idle", bus.state, 0);
    bus.start = 1'b1;
    hi = 0; lo = 0; falls = 0; n = 0;
    while (bus.state != 5 && n < 2000) begin
      @(negedge clock);
      n++;
      if (bus.cam_en) begin
        if (lo > 0) begin
          check("recover_low_len", lo, HOLD);
          lo = 0;
        end
        hi++;
      end else begin
        if (hi > 0) begin
          check("enabled_len", hi, ARM + SOFT);
          hi = 0;
          falls++;
        end
        lo++;
      end
    end
    check("fail_state", bus.state, 5);
    check("fail_cam_en", bus.cam_en, 0);
    check("recover_count", falls, MR);
    m_ecnt = (m_ecnt + MR > 255) ? 255 : m_ecnt + MR;
    check("err_cnt_after_wdog", bus.err_cnt, stat(m_ecnt));
    repeat (10) @(negedge clock);
    check("fail_sticky", bus.state, 5);
    bus.start = 1'b0;
    @(negedge clock);
    check("fail_to_idle", bus.state, 0);
    check("fail_idle_cam_en", bus.cam_en, 0);

    // Asynchronous reset in the middle of a frame.
    bus.start = 1'b1;
    wait_state(2, 40, "rearm_wait_sof");
    bus.in_frame = 1'b1;
    @(negedge clock);
    bus.in_line = 1'b1; bus.pix_vld = 1'b1;
    wait_state(3, 10, "rearm_stream");
    repeat (3) @(negedge clock);
    c = cyc;
    reset_n = 1'b0;
    #1;
    check("mid_rst_state", bus.state, 0);
    check("mid_rst_cam_en", bus.cam_en, 0);
    check("mid_rst_line_cnt", bus.line_cnt, 0);
    check("mid_rst_frame_ok", bus.frame_ok, 0);
    check("mid_rst_geom_err", bus.geom_err, 0);
    check("mid_rst_frame_cnt", bus.frame_cnt, 0);
    check("mid_rst_err_cnt", bus.err_cnt, 0);
    bus.in_line = 1'b0; bus.pix_vld = 1'b0; bus.in_frame = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    check("scoreboard_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
